// File: rtl/uaz_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uaz_bus_pkg
// Purpose  : Shared constants and types for the MicroUAZ data-bus slave.
// Revision : 1.0 - initial release
// ============================================================================
package uaz_bus_pkg;

    localparam int DATA_W = 8;

    localparam logic [7:0] ADDR_PORTOUTA   = 8'hF0;
    localparam logic [7:0] ADDR_PORTOUTB   = 8'hF1;
    localparam logic [7:0] ADDR_PORTINA    = 8'hF2;
    localparam logic [7:0] ADDR_PORTINB    = 8'hF3;
    localparam logic [7:0] ADDR_TMR_COUNT  = 8'hF4;
    localparam logic [7:0] ADDR_TMR_RELOAD = 8'hF5;
    localparam logic [7:0] ADDR_TMR_CTRL   = 8'hF6;
    localparam logic [7:0] ADDR_SCRATCH    = 8'hF7;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_OVF   = 1;
    localparam int CTRL_IRQEN = 2;

    // Member order places EN at bit 0, matching the register layout.
    typedef struct packed {
        logic irqen;
        logic ovf;
        logic en;
    } tmr_ctrl_t;

endpackage : uaz_bus_pkg
`default_nettype wire

// File: rtl/uaz_timer8.sv
`default_nettype none
// ============================================================================
// Module   : uaz_timer8
// Purpose  : 8-bit prescaled timer with sticky overflow flag and level IRQ.
//            Present only when UAZ_BUS_TIMER_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`ifdef UAZ_BUS_TIMER_EN
module uaz_timer8
    import uaz_bus_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_reload_i,
    input  logic              wr_ctrl_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] count_o,
    output logic [DATA_W-1:0] reload_o,
    output logic [DATA_W-1:0] ctrl_o,
    output logic              irq_o
);

    logic [DATA_W-1:0] ps_q, ps_d;
    logic [DATA_W-1:0] count_q, count_d;
    logic [DATA_W-1:0] reload_q, reload_d;
    tmr_ctrl_t         ctrl_q, ctrl_d;
    logic              irq_q;
    logic              wdata_unused;

    assign wdata_unused = ^wdata_i[7:3];

    always_comb begin
        ps_d     = ps_q;
        count_d  = count_q;
        reload_d = reload_q;
        ctrl_d   = ctrl_q;

        if (wr_reload_i) begin
            reload_d = wdata_i;
        end
        if (wr_ctrl_i) begin
            ctrl_d.en    = wdata_i[CTRL_EN];
            ctrl_d.irqen = wdata_i[CTRL_IRQEN];
            if (wdata_i[CTRL_OVF]) begin
                ctrl_d.ovf = 1'b0;
            end
        end

        // Reload uses the pre-write value so a new reload applies next period.
        if (ctrl_q.en) begin
            if (ps_q == '0) begin
                ps_d    = reload_q;
                count_d = count_q + 8'd1;
                if (count_q == 8'hFF) begin
                    ctrl_d.ovf = 1'b1;
                end
            end else begin
                ps_d = ps_q - 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ps_q     <= '0;
            count_q  <= '0;
            reload_q <= '0;
            ctrl_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            ps_q     <= ps_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            ctrl_q   <= ctrl_d;
            irq_q    <= ctrl_d.ovf & ctrl_d.irqen;
        end
    end

    assign count_o  = count_q;
    assign reload_o = reload_q;
    assign ctrl_o   = {5'b0, ctrl_q};
    assign irq_o    = irq_q;

endmodule : uaz_timer8
`endif
`default_nettype wire

// File: rtl/uaz_data_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uaz_data_bus_ctrl
// Purpose  : Data-side bus slave for MicroUAZ: RAM, port latches, synchronised
//            inputs, scratch and optional timer (UAZ_BUS_TIMER_EN).
// Revision : 1.0 - initial release
// ============================================================================
module uaz_data_bus_ctrl
    import uaz_bus_pkg::*;
#(
    parameter logic [7:0] RAM_TOP     = 8'hEF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic [DATA_W-1:0] i_Addressdata_Bus,
    input  logic [DATA_W-1:0] i_Dataout_Bus,
    input  logic              i_ReadWrite,
    output logic [DATA_W-1:0] o_DataIn_Bus,
    input  logic [DATA_W-1:0] i_PortInA,
    input  logic [DATA_W-1:0] i_PortInB,
    output logic [DATA_W-1:0] o_PortOutA,
    output logic [DATA_W-1:0] o_PortOutB,
    output logic              o_TimerIrq
);

    localparam int RAM_DEPTH = int'(RAM_TOP) + 1;

    logic [DATA_W-1:0] mem_q [RAM_DEPTH];
    logic [DATA_W-1:0] porta_q, portb_q, scratch_q;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic [SYNC_STAGES-1:0][DATA_W-1:0] sync_a_q, sync_b_q;
    logic [DATA_W-1:0] tmr_count, tmr_reload, tmr_ctrl;
    logic              tmr_irq;
    logic              is_ram;

    assign is_ram = (i_Addressdata_Bus <= RAM_TOP);

    always_ff @(posedge i_Clk) begin
        if (i_ReadWrite && is_ram) begin
            mem_q[i_Addressdata_Bus] <= i_Dataout_Bus;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            porta_q   <= '0;
            portb_q   <= '0;
            scratch_q <= '0;
            sync_a_q  <= '0;
            sync_b_q  <= '0;
            rd_q      <= '0;
        end else begin
            if (i_ReadWrite) begin
                case (i_Addressdata_Bus)
                    ADDR_PORTOUTA: porta_q   <= i_Dataout_Bus;
                    ADDR_PORTOUTB: portb_q   <= i_Dataout_Bus;
                    ADDR_SCRATCH:  scratch_q <= i_Dataout_Bus;
                    default: ;
                endcase
            end
            sync_a_q <= {sync_a_q[SYNC_STAGES-2:0], i_PortInA};
            sync_b_q <= {sync_b_q[SYNC_STAGES-2:0], i_PortInB};
            rd_q     <= rd_d;
        end
    end

    // Reads sample pre-edge state, so a same-cycle write returns the old value.
    always_comb begin
        rd_d = '0;
        if (is_ram) begin
            rd_d = mem_q[i_Addressdata_Bus];
        end else begin
            case (i_Addressdata_Bus)
                ADDR_PORTOUTA:   rd_d = porta_q;
                ADDR_PORTOUTB:   rd_d = portb_q;
                ADDR_PORTINA:    rd_d = sync_a_q[SYNC_STAGES-1];
                ADDR_PORTINB:    rd_d = sync_b_q[SYNC_STAGES-1];
                ADDR_TMR_COUNT:  rd_d = tmr_count;
                ADDR_TMR_RELOAD: rd_d = tmr_reload;
                ADDR_TMR_CTRL:   rd_d = tmr_ctrl;
                ADDR_SCRATCH:    rd_d = scratch_q;
                default:         rd_d = '0;
            endcase
        end
    end

`ifdef UAZ_BUS_TIMER_EN
    uaz_timer8 u_timer8 (
        .clk_i       (i_Clk),
        .rst_ni      (i_Reset),
        .wr_reload_i (i_ReadWrite && (i_Addressdata_Bus == ADDR_TMR_RELOAD)),
        .wr_ctrl_i   (i_ReadWrite && (i_Addressdata_Bus == ADDR_TMR_CTRL)),
        .wdata_i     (i_Dataout_Bus),
        .count_o     (tmr_count),
        .reload_o    (tmr_reload),
        .ctrl_o      (tmr_ctrl),
        .irq_o       (tmr_irq)
    );
`else
    // Without the timer its registers read as unmapped space.
    assign tmr_count  = '0;
    assign tmr_reload = '0;
    assign tmr_ctrl   = '0;
    assign tmr_irq    = 1'b0;
`endif

    assign o_DataIn_Bus = rd_q;
    assign o_PortOutA   = porta_q;
    assign o_PortOutB   = portb_q;
    assign o_TimerIrq   = tmr_irq;

endmodule : uaz_data_bus_ctrl
`default_nettype wire

// File: tb/tb_uaz_data_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uaz_data_bus_ctrl
// Purpose  : Directed, table-driven self-checking bench for uaz_data_bus_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uaz_data_bus_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] addr, dout, din, pina, pinb, pouta, poutb;
    logic       rw, irq;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        logic       w;
        logic       chk_rd;
        logic [7:0] exp_rd;
        logic [7:0] exp_pa;
        logic [7:0] exp_pb;
    } vec_t;

    vec_t vecs[$];

    uaz_data_bus_ctrl dut (
        .i_Clk             (clk),
        .i_Reset           (rst_n),
        .i_Addressdata_Bus (addr),
        .i_Dataout_Bus     (dout),
        .i_ReadWrite       (rw),
        .o_DataIn_Bus      (din),
        .i_PortInA         (pina),
        .i_PortInB         (pinb),
        .o_PortOutA        (pouta),
        .o_PortOutB        (poutb),
        .o_TimerIrq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus cycle; outputs are sampled 1 time unit after the edge.
    task automatic cyc(input logic [7:0] a, input logic [7:0] d, input logic w);
        addr = a;
        dout = d;
        rw   = w;
        @(posedge clk);
        #1;
    endtask

    // Async reset asserted between edges; outputs must clear without a clock.
    task automatic mid_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_rd", din, 8'h00);
        chk("rst_pa", pouta, 8'h00);
        chk("rst_pb", poutb, 8'h00);
        chk("rst_irq", {7'b0, irq}, 8'h00);
        rw = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        addr  = 8'h00;
        dout  = 8'h00;
        rw    = 1'b0;
        pina  = 8'h00;
        pinb  = 8'hA5;

        vecs.push_back('{8'hF0, 8'hC3, 1'b1, 1'b1, 8'h00, 8'hC3, 8'h00});
        vecs.push_back('{8'hF1, 8'h96, 1'b1, 1'b1, 8'h00, 8'hC3, 8'h96});
        vecs.push_back('{8'hF0, 8'h00, 1'b0, 1'b1, 8'hC3, 8'hC3, 8'h96});
        vecs.push_back('{8'hF1, 8'h00, 1'b0, 1'b1, 8'h96, 8'hC3, 8'h96});
        vecs.push_back('{8'h10, 8'h5A, 1'b1, 1'b0, 8'h00, 8'hC3, 8'h96});
        vecs.push_back('{8'h10, 8'h00, 1'b0, 1'b1, 8'h5A, 8'hC3, 8'h96});
        vecs.push_back('{8'hF9, 8'h55, 1'b1, 1'b1, 8'h00, 8'hC3, 8'h96});
        vecs.push_back('{8'hF9, 8'h00, 1'b0, 1'b1, 8'h00, 8'hC3, 8'h96});
        vecs.push_back('{8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 8'hC3, 8'h96});
        vecs.push_back('{8'hF2, 8'h77, 1'b1, 1'b1, 8'h00, 8'hC3, 8'h96});
        vecs.push_back('{8'hF2, 8'h00, 1'b0, 1'b1, 8'h00, 8'hC3, 8'h96});
        vecs.push_back('{8'hF3, 8'h00, 1'b0, 1'b1, 8'hA5, 8'hC3, 8'h96});
        vecs.push_back('{8'hF7, 8'h3E, 1'b1, 1'b1, 8'h00, 8'hC3, 8'h96});
        vecs.push_back('{8'hF7, 8'h00, 1'b0, 1'b1, 8'h3E, 8'hC3, 8'h96});
        vecs.push_back('{8'hEF, 8'h81, 1'b1, 1'b0, 8'h00, 8'hC3, 8'h96});
        vecs.push_back('{8'hEF, 8'h00, 1'b0, 1'b1, 8'h81, 8'hC3, 8'h96});
        vecs.push_back('{8'h00, 8'h11, 1'b1, 1'b0, 8'h00, 8'hC3, 8'h96});
        vecs.push_back('{8'h00, 8'h00, 1'b0, 1'b1, 8'h11, 8'hC3, 8'h96});
        vecs.push_back('{8'h20, 8'h11, 1'b1, 1'b0, 8'h00, 8'hC3, 8'h96});
        vecs.push_back('{8'h20, 8'hAA, 1'b1, 1'b1, 8'h11, 8'hC3, 8'h96});
        vecs.push_back('{8'h20, 8'h00, 1'b0, 1'b1, 8'hAA, 8'hC3, 8'h96});

        repeat (3) @(posedge clk);
        #1;
        chk("reset_rd", din, 8'h00);
        chk("reset_pa", pouta, 8'h00);
        chk("reset_pb", poutb, 8'h00);
        chk("reset_irq", {7'b0, irq}, 8'h00);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            cyc(vecs[i].a, vecs[i].d, vecs[i].w);
            if (vecs[i].chk_rd) chk($sformatf("vec%0d_rd", i), din, vecs[i].exp_rd);
            chk($sformatf("vec%0d_pa", i), pouta, vecs[i].exp_pa);
            chk($sformatf("vec%0d_pb", i), poutb, vecs[i].exp_pb);
        end

        // Input synchroniser: visible from the third edge after the change.
        pina = 8'h3C;
        cyc(8'hF2, 8'h00, 1'b0);
        chk("sync_e1", din, 8'h00);
        cyc(8'hF2, 8'h00, 1'b0);
        chk("sync_e2", din, 8'h00);
        cyc(8'hF2, 8'h00, 1'b0);
        chk("sync_e3", din, 8'h3C);

`ifdef UAZ_BUS_TIMER_EN
        cyc(8'hF5, 8'h02, 1'b1);
        cyc(8'hF5, 8'h00, 1'b0);
        chk("reload_rd", din, 8'h02);
        cyc(8'hF6, 8'h05, 1'b1);
        for (int k = 1; k <= 769; k++) begin
            logic [7:0] e;
            e = 8'(((k + 1) / 3) % 256);
            cyc(8'hF4, 8'h00, 1'b0);
            if (din !== e) chk($sformatf("count_k%0d", k), din, e);
            else total++;
            if (irq !== (k >= 766)) chk($sformatf("irq_k%0d", k), {7'b0, irq}, {7'b0, (k >= 766)});
            else total++;
        end
        cyc(8'hF6, 8'h00, 1'b0);
        chk("ctrl_ovf", din, 8'h07);
        cyc(8'hF6, 8'h07, 1'b1);
        chk("irq_clr", {7'b0, irq}, 8'h00);
        cyc(8'hF6, 8'h00, 1'b0);
        chk("ctrl_clr", din, 8'h05);

        mid_reset();
        cyc(8'hF4, 8'h00, 1'b0);
        chk("count_after_rst", din, 8'h00);
        cyc(8'hF6, 8'h00, 1'b0);
        chk("ctrl_after_rst", din, 8'h00);

        // Reload 0: count steps every cycle; clear and wrap collide at 0xFF.
        cyc(8'hF6, 8'h01, 1'b1);
        for (int k = 1; k <= 255; k++) begin
            cyc(8'hF4, 8'h00, 1'b0);
            if (din !== 8'(k - 1)) chk($sformatf("cnt0_k%0d", k), din, 8'(k - 1));
            else total++;
        end
        cyc(8'hF6, 8'h02, 1'b1);
        chk("setwins_old", din, 8'h01);
        cyc(8'hF6, 8'h00, 1'b0);
        chk("setwins_ovf", din, 8'h02);
        cyc(8'hF4, 8'h00, 1'b0);
        chk("frozen_count", din, 8'h00);
        cyc(8'hF4, 8'h00, 1'b0);
        chk("frozen_count2", din, 8'h00);
        chk("setwins_irq", {7'b0, irq}, 8'h00);
`else
        cyc(8'hF4, 8'h12, 1'b1);
        cyc(8'hF5, 8'h34, 1'b1);
        cyc(8'hF6, 8'h07, 1'b1);
        cyc(8'hF4, 8'h00, 1'b0);
        chk("nt_count", din, 8'h00);
        cyc(8'hF5, 8'h00, 1'b0);
        chk("nt_reload", din, 8'h00);
        cyc(8'hF6, 8'h00, 1'b0);
        chk("nt_ctrl", din, 8'h00);
        chk("nt_irq", {7'b0, irq}, 8'h00);
`endif

        cyc(8'h10, 8'h00, 1'b0);
        chk("pre_rst_rd", din, 8'h5A);
        mid_reset();
        cyc(8'h10, 8'h00, 1'b0);
        chk("ram_kept", din, 8'h5A);
        cyc(8'hF0, 8'h00, 1'b0);
        chk("pa_after_rst", din, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_uaz_data_bus_ctrl
`default_nettype wire

// File: doc/uaz_data_bus_ctrl.md
Name: uaz_data_bus_ctrl

Overview:
Data-side bus slave sitting directly downstream of the MicroUAZ core.
- Consumes the core's data address, data out and ReadWrite.
- Returns read data on the core's data-in bus.
- Implements on-chip data RAM, two output port latches, two synchronised input ports and an 8-bit prescaled timer, all memory-mapped in the 8-bit data address space.

Parameters:
RAM_TOP, 8'hEF, highest RAM address; RAM spans 0x00..RAM_TOP.
SYNC_STAGES, 2, flip-flop stages on each input port (minimum 2).

Ports:
i_Clk  in  1  system clock, rising edge.
i_Reset  in  1  asynchronous, active-low reset.
i_Addressdata_Bus  in  8  data address from core.
i_Dataout_Bus  in  8  write data from core.
i_ReadWrite  in  1  1 = write, 0 = read.
o_DataIn_Bus  out  8  read data to core (registered).
i_PortInA  in  8  asynchronous external input A.
i_PortInB  in  8  asynchronous external input B.
o_PortOutA  out  8  output latch A.
o_PortOutB  out  8  output latch B.
o_TimerIrq  out  1  timer overflow interrupt, level.

Behaviour:
- Reset (i_Reset=0, async):
  - o_DataIn_Bus, o_PortOutA/B, timer count, prescale reload, control and o_TimerIrq all go to 0.
  - Synchroniser flops go to 0.
  - RAM contents are not reset.
- Access rules:
  - Every cycle is an access; no handshake and no wait states.
  - Write: on the rising edge with i_ReadWrite=1, i_Dataout_Bus is committed to the addressed location.
  - Read: o_DataIn_Bus is updated on every rising edge with the content of the location addressed in that cycle, i.e. 1-cycle read latency.
  - Read data is captured while i_ReadWrite=1 as well; the core ignores it.
  - Read of the address being written in the same cycle returns the old value.
- Address map:
  - 0x00..RAM_TOP: RAM, R/W.
  - 0xF0: PortOutA, R/W.
  - 0xF1: PortOutB, R/W.
  - 0xF2: PortInA, synchronised, read-only; writes ignored.
  - 0xF3: PortInB, synchronised, read-only; writes ignored.
  - 0xF4: timer count, read-only.
  - 0xF5: prescale reload, R/W.
  - 0xF6: control.
    - bit0 EN.
    - bit1 OVF: sticky; write 1 to clear, write 0 no effect.
    - bit2 IRQEN.
    - bits7:3 read 0.
  - 0xF7: scratch, R/W.
  - Unmapped (RAM_TOP+1..0xEF, 0xF8..0xFF): reads 0x00, writes ignored.
- Timer:
  - Prescale counter PS counts down only while EN=1.
  - When PS==0: PS reloads from the reload register and count increments by 1.
  - Count wraps 0xFF->0x00; on that wrap OVF is set.
  - Writing the reload register while running takes effect at the next reload only.
  - EN=0 freezes PS and count; neither is cleared.
  - Reload=0 increments count every enabled cycle.
  - o_TimerIrq = OVF & IRQEN, registered with the flag.
  - OVF set and a software clear in the same cycle: set wins.
- Input ports: SYNC_STAGES-deep synchronisers. A change on i_PortInA is visible in a read of 0xF2 captured SYNC_STAGES+1 edges after the change.

Optional Feature:
UAZ_BUS_TIMER_EN.
- Defined: timer and addresses 0xF4..0xF6 present as above.
- Undefined: no timer logic; 0xF4..0xF6 behave as unmapped (read 0x00, writes ignored); o_TimerIrq tied to 0.

Decomposition:
- Package uaz_bus_pkg holds:
  - Address constants: ADDR_PORTOUTA .. ADDR_SCRATCH.
  - Control bit indices: CTRL_EN, CTRL_OVF, CTRL_IRQEN.
  - Data width constant 8.
- Sub-module uaz_timer8 holds the prescaler, count, OVF and IRQ; it is instantiated only under UAZ_BUS_TIMER_EN.

Test Plan:
- Write 0x5A to 0x10, then read 0x10 -> o_DataIn_Bus=0x5A one edge after the read address; read 0xF9 -> 0x00.
- Write 0xC3 to 0xF0 -> o_PortOutA=0xC3 after that edge; write 0x77 to 0xF2 -> ignored; drive i_PortInA=0x3C -> read of 0xF2 returns 0x3C only from the 3rd edge on (SYNC_STAGES=2).
- Reload=2, ctrl=0x05 -> count increments every 3 cycles; after 768 enabled cycles count=0x00, OVF=1, o_TimerIrq=1; write 0x07 to 0xF6 -> OVF clears and IRQ drops.
- Count at 0xFF with PS=0 and a write of 0x02 to 0xF6 in the same cycle -> OVF=1 (set wins).
- Write 0xAA to 0x20 and read 0x20 in the same cycle (RAM previously 0x11) -> returns 0x11; next read returns 0xAA.
- Assert i_Reset low mid-count between edges -> all outputs 0 immediately; RAM at 0x10 still 0x5A after release.
